// File: rtl/reduce_arb.sv
// ---------------------------------------------------------------------------
// reduce_arb
//
// Shares one combinational mod-p reduction datapath (p = 2^N - 19, N = 255 for
// Curve25519) among NREQ requesters. A round-robin arbiter picks a requester
// while idle. The chosen 2N-bit operand is registered and drives the reduction
// logic for LAT cycles, which makes it a multicycle path. The canonical N-bit
// residue is then captured and returned over a valid/ready response port.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_req_valid  [NREQ]        per-requester operand valid
//   o_req_ready  [NREQ]        per-requester accept strobe, at most one bit set
//   i_req_n      [NREQ*2N]     packed operands, requester i at [i*2N +: 2N]
//   o_rsp_valid                residue available
//   i_rsp_ready                consumer takes residue
//   o_rsp_id     [clog2(NREQ)] requester that owns o_rsp_r
//   o_rsp_r      [N]           operand mod p, always in 0 .. p-1
//   o_busy                     FSM not idle
// ---------------------------------------------------------------------------
module reduce_arb #(
    parameter int N    = 255,
    parameter int NREQ = 2,
    parameter int LAT  = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREQ-1:0]        i_req_valid,
    output logic [NREQ-1:0]        o_req_ready,
    input  logic [NREQ*2*N-1:0]    i_req_n,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [IDW-1:0]         o_rsp_id,
    output logic [N-1:0]           o_rsp_r,
    output logic                   o_busy
);

    localparam int OPW = 2 * N;
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [N-1:0] PRIME = {N{1'b1}} - N'(18);

    if (LAT < 1) begin : g_bad_lat
        $fatal(1, "reduce_arb: LAT must be at least 1");
    end
    if (NREQ < 2) begin : g_bad_nreq
        $fatal(1, "reduce_arb: NREQ must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_id;
    logic [CW-1:0]      r_cnt;
    logic [OPW-1:0]     r_operand;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [N-1:0]       r_rsp_r;

    logic               w_found;
    logic [IDW-1:0]     w_grant;
    logic [IDW:0]       w_sum;
    logic [IDW:0]       w_ptr_sum;
    logic [IDW-1:0]     w_ptr_next;
    logic               w_accept;
    logic [OPW-1:0]     w_operand;
    logic               w_capture;
    logic               w_rsp_done;

    logic [N+4:0]       w_fold1;
    logic [N:0]         w_fold2;
    logic [N-1:0]       w_fold3;
    logic [N-1:0]       w_residue;

    // Round-robin search: the first valid requester at or after the pointer,
    // wrapping modulo NREQ. The sum is one bit wider so the wrap works for
    // NREQ values that are not powers of two.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!w_found && i_req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_sum[IDW-1:0];
            end
        end
    end

    // Ready goes only to the granted requester, and only while idle. It is
    // forced low during reset so nothing looks accepted while the block is
    // held in reset.
    always_comb begin
        o_req_ready = '0;
        if (r_state == S_IDLE && w_found && !i_rst) begin
            o_req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept = |(i_req_valid & o_req_ready);

    // Pointer moves to the requester just after the one granted, so the
    // winner has the lowest priority next time.
    always_comb begin
        w_ptr_sum  = {1'b0, w_grant} + (IDW+1)'(1);
        w_ptr_next = w_ptr_sum[IDW-1:0];
        if (w_ptr_sum >= (IDW+1)'(NREQ)) begin
            w_ptr_next = '0;
        end
    end

    // Operand mux driven by the grant index.
    always_comb begin
        w_operand = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant == IDW'(k)) begin
                w_operand = i_req_n[k*OPW +: OPW];
            end
        end
    end

    // Reduction by folding, using 2^N == 19 (mod p).
    // fold1: hi*19 + lo < 20*2^N, so it fits in N+5 bits.
    // fold2: the top 5 bits (at most 19) fold again, giving less than 2^N + 361.
    // fold3: a leftover carry at bit N folds to +19. When that carry is set,
    //        the low bits are below 361, so the sum cannot overflow.
    // The result is now below 2^N = p + 19, so one conditional subtract
    // makes it canonical.
    assign w_fold1   = (N+5)'(r_operand[N-1:0])
                     + (N+5)'(r_operand[OPW-1:N]) * (N+5)'(19);
    assign w_fold2   = (N+1)'(w_fold1[N-1:0])
                     + (N+1)'(w_fold1[N+4:N]) * (N+1)'(19);
    assign w_fold3   = w_fold2[N-1:0] + (w_fold2[N] ? N'(19) : N'(0));
    assign w_residue = (w_fold3 >= PRIME) ? (w_fold3 - PRIME) : w_fold3;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A response handshake returns to IDLE. No accept can
    // happen on that edge, because ready is only raised from IDLE.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                    w_capture    = 1'b1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_next = S_IDLE;
                    w_rsp_done   = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers. The operand register stays stable through CALC, so
    // the reduction logic has LAT cycles to settle before its result is
    // captured.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_operand   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_r     <= '0;
        end else begin
            if (w_accept) begin
                r_operand <= w_operand;
                r_id      <= w_grant;
                r_ptr     <= w_ptr_next;
                r_cnt     <= CW'(LAT - 1);
            end else if (r_state == S_CALC && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_capture) begin
                r_rsp_r     <= w_residue;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_r     = r_rsp_r;
    assign o_busy      = (r_state != S_IDLE);

endmodule
